// File: rtl/front_panel_buttons.sv
// Front-panel switch conditioner: synchronize, debounce, latch each press, and issue
// presses one at a time as single-cycle command pulses, gated by downstream busy.
module front_panel_buttons #(
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLDOFF         = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  input  logic            busy,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_pulse,
  output logic [N_SW-1:0] pending
);

  localparam int HO_W = $clog2(HOLDOFF + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_SW-1:0]  INV_MASK = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF);

  typedef enum logic [0:0] {IDLE, HOLD} state_e;

  state_e                       state_q, state_d;
  logic [HO_W-1:0]              holdoff_q, holdoff_d;
  logic [N_SW-1:0]              sync1_q, sync1_d;
  logic [N_SW-1:0]              sync2_q, sync2_d;
  logic [N_SW-1:0]              level_q, level_d;
  logic [N_SW-1:0]              pending_q, pending_d;
  logic [N_SW-1:0]              pulse_q, pulse_d;
  logic [N_SW-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SW-1:0]              rise;
  logic [N_SW-1:0]              lowest_sel;

  // Synchronizer and per-bit debounce counters.
  always_comb begin
    sync1_d = sw_raw ^ INV_MASK;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_SW; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise = level_d & ~level_q;
  end

  // Issue FSM. Pending set has priority over the clear of the bit being issued.
  always_comb begin
    state_d    = state_q;
    holdoff_d  = holdoff_q;
    pulse_d    = '0;
    lowest_sel = pending_q & (~pending_q + N_SW'(1));
    case (state_q)
      IDLE: begin
        if (!busy && (pending_q != '0)) begin
          pulse_d   = lowest_sel;
          holdoff_d = HO_LOAD;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        holdoff_d = holdoff_q - HO_W'(1);
        if (holdoff_q <= HO_W'(1)) begin
          holdoff_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~pulse_d) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      holdoff_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sw_level = level_q;
  assign sw_pulse = pulse_q;
  assign pending  = pending_q;

endmodule
